// File: rtl/relobi_mux_if.sv
// relobi_mux_if: bundle of N reliable-OBI ports; req/gnt/rvalid/rready triplicated, a/r single copy.
// Latency: none, plain wires.
// Backpressure: gnt throttles the request channel, rready throttles the response channel.
interface relobi_mux_if #(
  parameter int unsigned N      = 1,
  parameter int unsigned AWidth = 32,
  parameter int unsigned RWidth = 32
);
  logic [N-1:0][2:0]        req;
  logic [N-1:0][AWidth-1:0] a;
  logic [N-1:0][2:0]        rready;
  logic [N-1:0][2:0]        gnt;
  logic [N-1:0][2:0]        rvalid;
  logic [N-1:0][RWidth-1:0] r;

  modport master (output req, a, rready, input gnt, rvalid, r);
  modport slave  (input req, a, rready, output gnt, rvalid, r);
endinterface

// File: rtl/relobi_mux.sv
// relobi_mux: TMR'd round-robin N-to-1 reliable-OBI mux, in-order responses routed via triplicated ID FIFO.
// Latency: 0 cycles; gnt, rvalid and r pass through combinationally.
// Backpressure: mgr req and all grants drop while NumMaxTrans are outstanding; rready follows the head requester.
// Optional: define RELOBI_MUX_ARB_LOCK_EN to pin the arbitration choice while a request is stalled.
module relobi_mux #(
  parameter int unsigned NumSbrPorts = 2,
  parameter int unsigned NumMaxTrans = 2,
  parameter int unsigned AWidth      = 32,
  parameter int unsigned RWidth      = 32,
  parameter bit          UseRReady   = 1'b0,
  parameter bit          Integrity   = 1'b0,
  parameter int unsigned IdxWidth    = (NumSbrPorts > 1) ? $clog2(NumSbrPorts) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  relobi_mux_if.slave  sbr_ports,
  relobi_mux_if.master mgr_port,
  output logic [1:0]   fault_o
);

  localparam int unsigned PtrWidth = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned CntWidth = PtrWidth + 1;

  if (Integrity) begin : g_integrity_unsupported
    $fatal(1, "relobi_mux: integrity-protected OBI is not supported");
  end
  if (NumSbrPorts < 2) begin : g_too_few_ports
    $fatal(1, "relobi_mux: NumSbrPorts must be >= 2");
  end
  if (NumMaxTrans < 1) begin : g_no_trans
    $fatal(1, "relobi_mux: NumMaxTrans must be >= 1");
  end

  typedef struct packed {
    logic [IdxWidth-1:0] rr;
    logic [PtrWidth-1:0] wptr;
    logic [PtrWidth-1:0] rptr;
    logic [CntWidth-1:0] cnt;
`ifdef RELOBI_MUX_ARB_LOCK_EN
    logic                lock;
    logic [IdxWidth-1:0] lsel;
`endif
  } state_t;

  state_t              state_q [3];
  state_t              state_d [3];
  state_t              state_v;
  logic                state_mm;
  logic [IdxWidth-1:0] fifo_q  [3][NumMaxTrans];

  logic [2:0][IdxWidth-1:0] sel;
  logic [2:0][IdxWidth-1:0] head;
  logic [IdxWidth-1:0]      sel_v;
  logic                     sel_mm;
  logic [2:0] any_req, full, nonempty, mreq, mgnt, mrvalid, mrready, push, pop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    if (int'(p) >= int'(NumMaxTrans) - 1) return '0;
    return p + 1'b1;
  endfunction

  // Per-copy round-robin pick and handshake qualification, each copy from its own registers
  always_comb begin
    int k;
    k = 0;
    for (int c = 0; c < 3; c++) begin
      sel[c]     = state_q[c].rr;
      any_req[c] = 1'b0;
      // Walk downwards so the nearest requester at or after rr wins
      for (int i = int'(NumSbrPorts) - 1; i >= 0; i--) begin
        k = (int'(state_q[c].rr) + i) % int'(NumSbrPorts);
        if (sbr_ports.req[k][c]) begin
          sel[c]     = IdxWidth'(k);
          any_req[c] = 1'b1;
        end
      end
`ifdef RELOBI_MUX_ARB_LOCK_EN
      // A stalled request keeps its port so a and req stay stable until granted
      if (state_q[c].lock) begin
        sel[c]     = state_q[c].lsel;
        any_req[c] = (int'(state_q[c].lsel) < int'(NumSbrPorts)) &&
                     sbr_ports.req[state_q[c].lsel][c];
      end
`endif
      full[c]     = (state_q[c].cnt == CntWidth'(NumMaxTrans));
      nonempty[c] = (state_q[c].cnt != '0);
      mreq[c]     = any_req[c] && !full[c];
      mgnt[c]     = mgr_port.gnt[0][c];
      mrvalid[c]  = mgr_port.rvalid[0][c];
      head[c]     = fifo_q[c][state_q[c].rptr];
      mrready[c]  = 1'b1;
      if (UseRReady) begin
        mrready[c] = (int'(head[c]) < int'(NumSbrPorts)) ? sbr_ports.rready[head[c]][c] : 1'b0;
      end
      push[c] = mreq[c] && mgnt[c];
      pop[c]  = mrvalid[c] && mrready[c] && nonempty[c];
    end
  end

  // Majority-vote the registered state and the per-copy port choice
  always_comb begin
    state_v  = (state_q[0] & state_q[1]) | (state_q[0] & state_q[2]) | (state_q[1] & state_q[2]);
    state_mm = (state_q[0] != state_q[1]) || (state_q[0] != state_q[2]);
    sel_v    = (sel[0] & sel[1]) | (sel[0] & sel[2]) | (sel[1] & sel[2]);
    sel_mm   = (sel[0] != sel[1]) || (sel[0] != sel[2]);
  end

  // Drive the merged request and route grants/responses back to the requesters
  always_comb begin
    mgr_port.req    = '0;
    mgr_port.rready = '0;
    mgr_port.a      = '0;
    sbr_ports.gnt   = '0;
    sbr_ports.rvalid = '0;
    sbr_ports.r     = '0;
    mgr_port.req[0]    = mreq;
    mgr_port.rready[0] = mrready;
    if (int'(sel_v) < int'(NumSbrPorts)) begin
      mgr_port.a[0] = sbr_ports.a[sel_v];
    end
    for (int k = 0; k < int'(NumSbrPorts); k++) begin
      sbr_ports.r[k] = mgr_port.r[0];
      for (int c = 0; c < 3; c++) begin
        sbr_ports.gnt[k][c]    = mgnt[c] && !full[c] && (int'(sel[c]) == k);
        sbr_ports.rvalid[k][c] = mrvalid[c] && nonempty[c] && (int'(head[c]) == k);
      end
    end
    fault_o = {|(mrvalid & ~nonempty), state_mm | sel_mm};
  end

  // Advance every copy from the voted state so a single upset is overwritten next cycle
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      state_d[c] = state_v;
      if (push[c]) begin
        state_d[c].wptr = next_ptr(state_v.wptr);
        state_d[c].rr   = IdxWidth'((int'(sel[c]) + 1) % int'(NumSbrPorts));
      end
      if (pop[c]) begin
        state_d[c].rptr = next_ptr(state_v.rptr);
      end
      if (push[c] && !pop[c]) begin
        state_d[c].cnt = state_v.cnt + 1'b1;
      end else if (pop[c] && !push[c]) begin
        state_d[c].cnt = state_v.cnt - 1'b1;
      end
`ifdef RELOBI_MUX_ARB_LOCK_EN
      state_d[c].lock = mreq[c] && !mgnt[c];
      state_d[c].lsel = sel[c];
`endif
    end
  end

  // Triplicated state registers; FIFO copies are written independently and never voted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < 3; c++) begin
        state_q[c] <= '0;
        for (int e = 0; e < int'(NumMaxTrans); e++) begin
          fifo_q[c][e] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        state_q[c] <= state_d[c];
        if (push[c]) begin
          fifo_q[c][state_q[c].wptr] <= sel[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_relobi_mux.sv
// tb_relobi_mux: directed checks of arbitration, full stall, response routing, TMR upset and protocol faults.
// Latency: expects 0-cycle gnt/rvalid pass-through.
// Backpressure: exercises the NumMaxTrans=2 full stall and mgr gnt stalls.
`timescale 1ns/1ps
module tb_relobi_mux;
  localparam int unsigned NPorts = 3;
  localparam int unsigned AW     = 8;
  localparam int unsigned RW     = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [1:0] fault_o;
  int         total = 0;
  int         bad   = 0;

  relobi_mux_if #(.N(NPorts), .AWidth(AW), .RWidth(RW)) sbr_if ();
  relobi_mux_if #(.N(1),      .AWidth(AW), .RWidth(RW)) mgr_if ();

  relobi_mux #(
    .NumSbrPorts(NPorts),
    .NumMaxTrans(2),
    .AWidth     (AW),
    .RWidth     (RW),
    .UseRReady  (1'b1)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .sbr_ports(sbr_if),
    .mgr_port (mgr_if),
    .fault_o  (fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_inputs();
    sbr_if.req    = '0;
    sbr_if.rready = {NPorts{3'b111}};
    sbr_if.a      = {8'hA2, 8'hA1, 8'hA0};
    mgr_if.gnt    = '0;
    mgr_if.rvalid = '0;
    mgr_if.r      = '0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    tick();
    #1;
    if (mgr_if.req !== 3'b000) begin bad++; $display("FAIL reset_mreq got=%b exp=000", mgr_if.req); end
    total++;
    if (sbr_if.gnt !== 9'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0", sbr_if.gnt); end
    total++;
    if (sbr_if.rvalid !== 9'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", sbr_if.rvalid); end
    total++;
    if (fault_o !== 2'b00) begin bad++; $display("FAIL reset_fault got=%b exp=00", fault_o); end
    total++;
    tick();
    rst_ni = 1'b1;
  endtask

  // Port 1 alone, three requests against a two-deep ID FIFO
  task automatic test_full();
    tick(); sbr_if.req[1] = 3'b111; mgr_if.gnt = 3'b111; #1;
    if (sbr_if.gnt !== 9'b000_111_000) begin bad++; $display("FAIL full_gnt1 got=%b exp=000111000", sbr_if.gnt); end
    total++;
    if (mgr_if.a[0] !== 8'hA1) begin bad++; $display("FAIL full_a got=%h exp=a1", mgr_if.a[0]); end
    total++;
    tick(); #1;
    if (sbr_if.gnt !== 9'b000_111_000) begin bad++; $display("FAIL full_gnt2 got=%b exp=000111000", sbr_if.gnt); end
    total++;
    tick(); #1;
    if (mgr_if.req !== 3'b000) begin bad++; $display("FAIL full_mreq got=%b exp=000", mgr_if.req); end
    total++;
    if (sbr_if.gnt !== 9'b0) begin bad++; $display("FAIL full_gnt3_held got=%b exp=0", sbr_if.gnt); end
    total++;
    tick(); mgr_if.rvalid = 3'b111; mgr_if.r = 8'h5A; #1;
    if (sbr_if.gnt !== 9'b0) begin bad++; $display("FAIL full_gnt_during_pop got=%b exp=0", sbr_if.gnt); end
    total++;
    if (sbr_if.rvalid !== 9'b000_111_000) begin bad++; $display("FAIL full_rvalid1 got=%b exp=000111000", sbr_if.rvalid); end
    total++;
    if (sbr_if.r[1] !== 8'h5A) begin bad++; $display("FAIL full_r got=%h exp=5a", sbr_if.r[1]); end
    total++;
    if (fault_o !== 2'b00) begin bad++; $display("FAIL full_fault got=%b exp=00", fault_o); end
    total++;
    tick(); mgr_if.rvalid = 3'b000; #1;
    if (sbr_if.gnt !== 9'b000_111_000) begin bad++; $display("FAIL full_gnt3 got=%b exp=000111000", sbr_if.gnt); end
    total++;
    tick(); sbr_if.req = '0; mgr_if.rvalid = 3'b111; #1;
    if (sbr_if.rvalid !== 9'b000_111_000) begin bad++; $display("FAIL full_rvalid2 got=%b exp=000111000", sbr_if.rvalid); end
    total++;
    tick(); #1;
    if (sbr_if.rvalid !== 9'b000_111_000) begin bad++; $display("FAIL full_rvalid3 got=%b exp=000111000", sbr_if.rvalid); end
    total++;
    if (mgr_if.rready[0] !== 3'b111) begin bad++; $display("FAIL full_rready got=%b exp=111", mgr_if.rready[0]); end
    total++;
    tick(); mgr_if.rvalid = 3'b000;
  endtask

  // All three ports requesting; each response arrives the cycle after its grant
  task automatic test_round_robin();
    int          gport [6] = '{0, 1, 2, 0, 1, 2};
    logic [7:0]  ga    [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA0, 8'hA1, 8'hA2};
    logic [8:0]  exp;
    apply_reset();
    for (int n = 0; n < 7; n++) begin
      tick();
      sbr_if.req    = (n < 6) ? {NPorts{3'b111}} : '0;
      mgr_if.gnt    = 3'b111;
      mgr_if.rvalid = (n > 0) ? 3'b111 : 3'b000;
      mgr_if.r      = 8'h30 + 8'(n);
      #1;
      if (n < 6) begin
        exp = 9'b111 << (3 * gport[n]);
        if (sbr_if.gnt !== exp) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", n, sbr_if.gnt, exp); end
        total++;
        if (mgr_if.a[0] !== ga[n]) begin bad++; $display("FAIL rr_a[%0d] got=%h exp=%h", n, mgr_if.a[0], ga[n]); end
        total++;
        if (mgr_if.req[0] !== 3'b111) begin bad++; $display("FAIL rr_mreq[%0d] got=%b exp=111", n, mgr_if.req[0]); end
        total++;
      end
      if (n > 0) begin
        exp = 9'b111 << (3 * gport[n-1]);
        if (sbr_if.rvalid !== exp) begin bad++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", n, sbr_if.rvalid, exp); end
        total++;
        if (fault_o !== 2'b00) begin bad++; $display("FAIL rr_fault[%0d] got=%b exp=00", n, fault_o); end
        total++;
      end
    end
    tick(); mgr_if.rvalid = 3'b000;
  endtask

  // Ports 0 and 2 held off by mgr gnt=0 for four cycles
  task automatic test_stall();
    for (int n = 0; n < 4; n++) begin
      tick(); sbr_if.req = {3'b111, 3'b000, 3'b111}; mgr_if.gnt = 3'b000; #1;
      if (mgr_if.a[0] !== 8'hA0) begin bad++; $display("FAIL stall_a[%0d] got=%h exp=a0", n, mgr_if.a[0]); end
      total++;
      if (mgr_if.req[0] !== 3'b111) begin bad++; $display("FAIL stall_mreq[%0d] got=%b exp=111", n, mgr_if.req[0]); end
      total++;
      if (sbr_if.gnt !== 9'b0) begin bad++; $display("FAIL stall_gnt[%0d] got=%b exp=0", n, sbr_if.gnt); end
      total++;
    end
    tick(); mgr_if.gnt = 3'b111; #1;
    if (sbr_if.gnt !== 9'b000_000_111) begin bad++; $display("FAIL stall_gnt_p0 got=%b exp=000000111", sbr_if.gnt); end
    total++;
    tick(); #1;
    if (sbr_if.gnt !== 9'b111_000_000) begin bad++; $display("FAIL stall_gnt_p2 got=%b exp=111000000", sbr_if.gnt); end
    total++;
    if (mgr_if.a[0] !== 8'hA2) begin bad++; $display("FAIL stall_a_p2 got=%h exp=a2", mgr_if.a[0]); end
    total++;
    tick(); sbr_if.req = '0; mgr_if.rvalid = 3'b111; #1;
    if (sbr_if.rvalid !== 9'b000_000_111) begin bad++; $display("FAIL stall_rvalid_p0 got=%b exp=000000111", sbr_if.rvalid); end
    total++;
    tick(); #1;
    if (sbr_if.rvalid !== 9'b111_000_000) begin bad++; $display("FAIL stall_rvalid_p2 got=%b exp=111000000", sbr_if.rvalid); end
    total++;
    tick(); mgr_if.rvalid = 3'b000;
  endtask

  // Copy 1 misses a grant, leaving its rr/cnt/wptr registers upset for one cycle
  task automatic test_tmr_upset();
    tick(); sbr_if.req = {3'b000, 3'b000, 3'b111}; mgr_if.gnt = 3'b101; #1;
    if (fault_o !== 2'b00) begin bad++; $display("FAIL upset_fault_pre got=%b exp=00", fault_o); end
    total++;
    if (sbr_if.gnt !== 9'b000_000_101) begin bad++; $display("FAIL upset_gnt got=%b exp=000000101", sbr_if.gnt); end
    total++;
    tick(); sbr_if.req = '0; mgr_if.gnt = 3'b000; #1;
    if (fault_o !== 2'b01) begin bad++; $display("FAIL upset_fault got=%b exp=01", fault_o); end
    total++;
    tick(); mgr_if.rvalid = 3'b111; mgr_if.r = 8'h77; #1;
    if (fault_o !== 2'b00) begin bad++; $display("FAIL upset_fault_post got=%b exp=00", fault_o); end
    total++;
    if (sbr_if.rvalid !== 9'b000_000_111) begin bad++; $display("FAIL upset_rvalid got=%b exp=000000111", sbr_if.rvalid); end
    total++;
    if (sbr_if.r[0] !== 8'h77) begin bad++; $display("FAIL upset_r got=%h exp=77", sbr_if.r[0]); end
    total++;
    tick(); mgr_if.rvalid = 3'b000; sbr_if.req = {3'b111, 3'b000, 3'b000}; mgr_if.gnt = 3'b111; #1;
    if (sbr_if.gnt !== 9'b111_000_000) begin bad++; $display("FAIL upset_next_gnt got=%b exp=111000000", sbr_if.gnt); end
    total++;
    if (mgr_if.a[0] !== 8'hA2) begin bad++; $display("FAIL upset_next_a got=%h exp=a2", mgr_if.a[0]); end
    total++;
    tick(); sbr_if.req = '0; mgr_if.rvalid = 3'b111; #1;
    if (sbr_if.rvalid !== 9'b111_000_000) begin bad++; $display("FAIL upset_next_rvalid got=%b exp=111000000", sbr_if.rvalid); end
    total++;
    if (fault_o !== 2'b00) begin bad++; $display("FAIL upset_next_fault got=%b exp=00", fault_o); end
    total++;
    tick(); mgr_if.rvalid = 3'b000;
  endtask

  // Responses with no outstanding transaction, after reset and after a mid-transaction reset
  task automatic test_proto_err();
    apply_reset();
    tick(); mgr_if.rvalid = 3'b111; #1;
    if (sbr_if.rvalid !== 9'b0) begin bad++; $display("FAIL perr_rvalid got=%b exp=0", sbr_if.rvalid); end
    total++;
    if (fault_o !== 2'b10) begin bad++; $display("FAIL perr_fault got=%b exp=10", fault_o); end
    total++;
    tick(); mgr_if.rvalid = 3'b000; #1;
    if (fault_o !== 2'b00) begin bad++; $display("FAIL perr_fault_clear got=%b exp=00", fault_o); end
    total++;
    tick(); sbr_if.req[1] = 3'b111; mgr_if.gnt = 3'b111; #1;
    if (sbr_if.gnt !== 9'b000_111_000) begin bad++; $display("FAIL perr_gnt got=%b exp=000111000", sbr_if.gnt); end
    total++;
    tick(); sbr_if.req = '0; mgr_if.gnt = 3'b000; rst_ni = 1'b0;
    tick(); rst_ni = 1'b1;
    tick(); mgr_if.rvalid = 3'b111; #1;
    if (sbr_if.rvalid !== 9'b0) begin bad++; $display("FAIL perr_midrst_rvalid got=%b exp=0", sbr_if.rvalid); end
    total++;
    if (fault_o !== 2'b10) begin bad++; $display("FAIL perr_midrst_fault got=%b exp=10", fault_o); end
    total++;
    tick(); mgr_if.rvalid = 3'b000;
  endtask

  // Push and pop together at one outstanding entry
  task automatic test_push_pop();
    tick(); sbr_if.req = {3'b000, 3'b000, 3'b111}; mgr_if.gnt = 3'b111; #1;
    if (sbr_if.gnt !== 9'b000_000_111) begin bad++; $display("FAIL pp_gnt0 got=%b exp=000000111", sbr_if.gnt); end
    total++;
    tick(); sbr_if.req = {3'b111, 3'b000, 3'b000}; mgr_if.rvalid = 3'b111; #1;
    if (sbr_if.gnt !== 9'b111_000_000) begin bad++; $display("FAIL pp_gnt2 got=%b exp=111000000", sbr_if.gnt); end
    total++;
    if (sbr_if.rvalid !== 9'b000_000_111) begin bad++; $display("FAIL pp_rvalid0 got=%b exp=000000111", sbr_if.rvalid); end
    total++;
    if (fault_o !== 2'b00) begin bad++; $display("FAIL pp_fault got=%b exp=00", fault_o); end
    total++;
    tick(); sbr_if.req = '0; #1;
    if (sbr_if.rvalid !== 9'b111_000_000) begin bad++; $display("FAIL pp_rvalid2 got=%b exp=111000000", sbr_if.rvalid); end
    total++;
    tick(); #1;
    if (fault_o !== 2'b10) begin bad++; $display("FAIL pp_drained got=%b exp=10", fault_o); end
    total++;
    tick(); mgr_if.rvalid = 3'b000;
  endtask

  initial begin
    test_reset();
    test_full();
    test_round_robin();
    test_stall();
    test_tmr_upset();
    test_proto_err();
    test_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
